// File: rtl/punc_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : punc_ifetch
// Description : PUnC LC3 instruction fetch stage. Owns the fetch PC, issues
//               single-outstanding req/ack reads to instruction memory and
//               buffers up to DEPTH {instruction, PC+1} pairs for control.
//               Redirects flush the buffer; halt stops fetching until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module punc_ifetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] START_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  input  logic        ir_take,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_DROP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   fpc_q, fpc_d;
  logic [15:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_flag_q, halt_flag_d;
  logic [15:0]   word_q [DEPTH];
  logic [15:0]   word_d [DEPTH];
  logic [15:0]   pc_q   [DEPTH];
  logic [15:0]   pc_d   [DEPTH];

  logic          w_take;
  logic          w_push;
  logic          w_flush;
  logic [CW-1:0] w_count_after_take;

  // A redirect or halt flushes the buffer, so a same-cycle take is moot.
  assign w_flush            = redirect | halt;
  assign w_take             = ir_take & (count_q != '0) & ~w_flush;
  assign w_count_after_take = count_q - {{PW{1'b0}}, w_take};

  assign mem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
  assign mem_addr = req_addr_q;
  assign ir_valid = (count_q != '0);
  assign ir       = word_q[head_q];
  assign ir_pc    = pc_q[head_q];

  // Fetch sequencing: issue decision, ack handling, redirect/halt drop paths.
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    req_addr_d  = req_addr_q;
    halt_flag_d = halt_flag_q | halt;
    w_push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (redirect) begin
          fpc_d = redirect_pc;
        end else if (w_count_after_take < C_DEPTH) begin
          req_addr_d = fpc_q;
          fpc_d      = fpc_q + 16'd1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fpc_d = redirect_pc;
          if (mem_ack) state_d = halt ? S_HALTED : S_IDLE;
          else         state_d = S_DROP;
        end else if (halt) begin
          state_d = mem_ack ? S_HALTED : S_DROP;
        end else if (mem_ack) begin
          w_push  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        // The outstanding request must still complete; its data is discarded.
        if (redirect) fpc_d = redirect_pc;
        if (mem_ack) state_d = (halt_flag_q | halt) ? S_HALTED : S_IDLE;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  // Instruction buffer pointers, occupancy and storage.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    word_d  = word_q;
    pc_d    = pc_q;
    if (w_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) begin
        word_d[tail_q] = mem_rdata;
        pc_d[tail_q]   = req_addr_q + 16'd1;
        tail_d         = tail_q + 1'b1;
      end
      if (w_take) head_d = head_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_take};
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fpc_q       <= START_PC;
      req_addr_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      halt_flag_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      req_addr_q  <= req_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      halt_flag_q <= halt_flag_d;
      word_q      <= word_d;
      pc_q        <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_punc_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_punc_ifetch
// Description : Self-checking bench for punc_ifetch with a latency-configurable
//               memory responder returning addr ^ 16'hA5A5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_punc_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_take = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int lat     = 0;
  int wcnt    = 0;

  punc_ifetch #(.DEPTH(2), .START_PC(16'h3000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_take(ir_take),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory responder: ack after 'lat' waiting cycles; also checks address stability.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;
  always @(negedge clk) begin
    if (mem_req && prev_req && !prev_ack) chk("addr_stable", mem_addr, prev_addr);
    prev_req  = mem_req;
    prev_addr = mem_addr;
    if (mem_req && !rst) begin
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ 16'hA5A5;
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    prev_ack = mem_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; ir_take = 1'b0; lat = l;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        take;
    logic        v;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        req;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl [13];
  int   cnt;
  logic seen;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h3000};
    tbl[2]  = '{1'b1, 1'b1, 16'h95A5, 16'h3001, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h3001};
    tbl[4]  = '{1'b1, 1'b1, 16'h95A4, 16'h3002, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h3002};
    tbl[6]  = '{1'b0, 1'b1, 16'h95A7, 16'h3003, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 16'h95A7, 16'h3003, 1'b1, 16'h3003};
    tbl[8]  = '{1'b0, 1'b1, 16'h95A7, 16'h3003, 1'b0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 16'h95A7, 16'h3003, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b1, 16'h95A6, 16'h3004, 1'b1, 16'h3004};
    tbl[11] = '{1'b0, 1'b1, 16'h95A6, 16'h3004, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 1'b1, 16'h95A6, 16'h3004, 1'b0, 16'h0000};

    // Reset state and streaming / buffer-full behaviour.
    do_reset(0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d_req", i), {15'd0, mem_req}, {15'd0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {15'd0, ir_valid}, {15'd0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("v%0d_ir", i), ir, tbl[i].ir);
        chk($sformatf("v%0d_ir_pc", i), ir_pc, tbl[i].pc);
      end
      ir_take = tbl[i].take;
      tick();
    end

    // Redirect one cycle after issuing 3005 with 3-cycle memory latency.
    do_reset(3);
    redirect = 1'b1; redirect_pc = 16'h3005;
    tick();
    redirect = 1'b0;
    tick();
    chk("r3_issue_addr", mem_addr, 16'h3005);
    redirect = 1'b1; redirect_pc = 16'h4000;
    tick();
    redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("r3_req_held", {15'd0, mem_req}, 16'd1);
      chk("r3_addr_held", mem_addr, 16'h3005);
      chk("r3_valid0", {15'd0, ir_valid}, 16'd0);
      tick();
    end
    chk("r3_req_drop", {15'd0, mem_req}, 16'd0);
    tick();
    chk("r3_new_req", {15'd0, mem_req}, 16'd1);
    chk("r3_new_addr", mem_addr, 16'h4000);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = ir_valid;
    end
    chk("r3_valid_timeout", {15'd0, seen}, 16'd1);
    chk("r3_ir", ir, 16'hE5A5);
    chk("r3_ir_pc", ir_pc, 16'h4001);

    // Redirect coinciding with mem_ack and ir_take while one word is buffered.
    do_reset(0);
    tick(); tick(); tick();
    chk("rc_pre_valid", {15'd0, ir_valid}, 16'd1);
    chk("rc_pre_addr", mem_addr, 16'h3001);
    redirect = 1'b1; redirect_pc = 16'h5000; ir_take = 1'b1;
    tick();
    redirect = 1'b0; ir_take = 1'b0;
    chk("rc_flush_valid", {15'd0, ir_valid}, 16'd0);
    chk("rc_flush_req", {15'd0, mem_req}, 16'd0);
    tick();
    chk("rc_new_addr", mem_addr, 16'h5000);
    chk("rc_new_req", {15'd0, mem_req}, 16'd1);
    tick();
    chk("rc_ir", ir, 16'hF5A5);
    chk("rc_ir_pc", ir_pc, 16'h5001);

    // Halt while a request is outstanding, then restart by reset.
    do_reset(2);
    ir_take = 1'b1;
    tick();
    chk("h_req", {15'd0, mem_req}, 16'd1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_drop_req", {15'd0, mem_req}, 16'd1);
    tick();
    chk("h_drop_req2", {15'd0, mem_req}, 16'd1);
    tick();
    chk("h_after_ack_req", {15'd0, mem_req}, 16'd0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_req || ir_valid) cnt++;
      tick();
    end
    chk("h_quiet_cycles", 16'(cnt), 16'd0);
    do_reset(0);
    tick();
    chk("h_restart_addr", mem_addr, 16'h3000);
    chk("h_restart_req", {15'd0, mem_req}, 16'd1);

    // PC wrap from FFFF to 0000.
    do_reset(0);
    ir_take = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    tick();
    chk("w_addr_ffff", mem_addr, 16'hFFFF);
    tick();
    chk("w_ir", ir, 16'h5A5A);
    chk("w_ir_pc", ir_pc, 16'h0000);
    tick();
    chk("w_addr_0000", mem_addr, 16'h0000);
    tick();
    chk("w_ir2", ir, 16'hA5A5);
    chk("w_ir_pc2", ir_pc, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
